// File: rtl/pkt_tx_arbiter_pkg.sv
// Shared types and helpers for the MAC transmit packet arbiter.
package pkt_tx_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } arb_state_t;

  localparam int DATA_W_C = 64;
  localparam int MOD_W_C  = 3;
  localparam int CNT_W_C  = 16;

  // Next round-robin pointer: one past the source that just finished.
  function automatic int rr_next(input int ptr, input int num_src);
    return (ptr + 1 >= num_src) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/pkt_tx_arbiter_if.sv
// Source-side and MAC-side packet bus of the transmit arbiter.
// master: the arbiter; slave: sources plus MAC (or a testbench standing in for them).
interface pkt_tx_arb_if #(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = 64,
  parameter int MOD_W   = 3
);
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_sop;
  logic [NUM_SRC-1:0]        src_eop;
  logic [NUM_SRC*MOD_W-1:0]  src_mod;
  logic [NUM_SRC-1:0]        src_val;
  logic [NUM_SRC-1:0]        src_rdy;
  logic                      pkt_tx_full;
  logic [DATA_W-1:0]         pkt_tx_data;
  logic                      pkt_tx_sop;
  logic                      pkt_tx_eop;
  logic [MOD_W-1:0]          pkt_tx_mod;
  logic                      pkt_tx_val;

  modport master (
    input  src_data, src_sop, src_eop, src_mod, src_val, pkt_tx_full,
    output src_rdy, pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_val
  );

  modport slave (
    output src_data, src_sop, src_eop, src_mod, src_val, pkt_tx_full,
    input  src_rdy, pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_val
  );
endinterface

// File: rtl/pkt_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module pkt_tx_rr_pick #(
  parameter int NUM_SRC = 2,
  localparam int IDX_W  = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any_req
);

  // Walk NUM_SRC positions starting at ptr; the first hit wins.
  always_comb begin
    int j;
    j       = 0;
    gnt_idx = '0;
    any_req = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (!any_req && req[IDX_W'(j)]) begin
        any_req = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/pkt_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of the MAC pkt_tx port.
// A granted source owns the port from SOP to EOP; pkt_tx_full stalls only it.
// Optional per-source packet counters: define PKT_TX_ARB_STATS_EN.
module pkt_tx_arbiter
  import pkt_tx_arb_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = DATA_W_C,
  parameter int MOD_W   = MOD_W_C
) (
  input  logic               clk_156m25,
  input  logic               reset_156m25_n,
  pkt_tx_arb_if.master       bus,
  output logic               proto_err
`ifdef PKT_TX_ARB_STATS_EN
  ,
  input  logic               stats_clr,
  output logic [NUM_SRC*CNT_W_C-1:0] src_pkt_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_SRC);

  arb_state_t state;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] rr_ptr;
  logic             pkt_first;   // next accepted word is the packet's opening SOP
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             acc;

  logic [NUM_SRC-1:0][DATA_W-1:0] s_data;
  logic [NUM_SRC-1:0][MOD_W-1:0]  s_mod;

  logic [DATA_W-1:0] tx_data;
  logic              tx_sop;
  logic              tx_eop;
  logic [MOD_W-1:0]  tx_mod;
  logic              tx_val;

  assign s_data = bus.src_data;
  assign s_mod  = bus.src_mod;

  // Only a word that opens a packet may win arbitration.
  pkt_tx_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req     (bus.src_val & bus.src_sop),
    .ptr     (rr_ptr),
    .gnt_idx (pick_idx),
    .any_req (pick_any)
  );

  assign acc = (state == PASS) && bus.src_val[grant] && !bus.pkt_tx_full;

  // Ready goes to the owner only, and drops the same cycle the MAC reports full.
  always_comb begin
    bus.src_rdy = '0;
    if (state == PASS && !bus.pkt_tx_full) bus.src_rdy = NUM_SRC'(1) << grant;
  end

  // Arbitration FSM plus registered MAC-side word; data fields hold when idle.
  always_ff @(posedge clk_156m25) begin
    if (!reset_156m25_n) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      pkt_first <= 1'b0;
      proto_err <= 1'b0;
      tx_data   <= '0;
      tx_sop    <= 1'b0;
      tx_eop    <= 1'b0;
      tx_mod    <= '0;
      tx_val    <= 1'b0;
    end else begin
      tx_val <= 1'b0;
      case (state)
        IDLE: begin
          // A mid-packet word with no owner is a source bug; it stays stalled.
          if (|(bus.src_val & ~bus.src_sop)) proto_err <= 1'b1;
          if (pick_any) begin
            grant     <= pick_idx;
            pkt_first <= 1'b1;
            state     <= PASS;
          end
        end
        PASS: begin
          if (acc) begin
            tx_data   <= s_data[grant];
            tx_sop    <= bus.src_sop[grant];
            tx_eop    <= bus.src_eop[grant];
            tx_mod    <= s_mod[grant];
            tx_val    <= 1'b1;
            pkt_first <= 1'b0;
            // A stray SOP inside a packet is forwarded as-is but flagged.
            if (bus.src_sop[grant] && !pkt_first) proto_err <= 1'b1;
            if (bus.src_eop[grant]) begin
              state  <= IDLE;
              rr_ptr <= IDX_W'(rr_next(int'(grant), NUM_SRC));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pkt_tx_data = tx_data;
  assign bus.pkt_tx_sop  = tx_sop;
  assign bus.pkt_tx_eop  = tx_eop;
  assign bus.pkt_tx_mod  = tx_mod;
  assign bus.pkt_tx_val  = tx_val;

`ifdef PKT_TX_ARB_STATS_EN
  logic [NUM_SRC-1:0][CNT_W_C-1:0] pkt_cnt;

  // Saturating per-source completed-packet counters; clear beats increment.
  always_ff @(posedge clk_156m25) begin
    if (!reset_156m25_n || stats_clr) begin
      pkt_cnt <= '0;
    end else if (acc && bus.src_eop[grant] && pkt_cnt[grant] != '1) begin
      pkt_cnt[grant] <= pkt_cnt[grant] + CNT_W_C'(1);
    end
  end

  assign src_pkt_cnt = pkt_cnt;
`endif

endmodule

// File: tb/tb_pkt_tx_arbiter.sv
// Randomized bench for pkt_tx_arbiter against a transaction-level reference model.
module tb_pkt_tx_arbiter;
  localparam int NS = 3;
  localparam int DW = 64;
  localparam int MW = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [MW-1:0] mod;
  } word_t;

  logic clk;
  logic rst_n;
  logic proto_err;

  pkt_tx_arb_if #(.NUM_SRC(NS), .DATA_W(DW), .MOD_W(MW)) bus ();

`ifdef PKT_TX_ARB_STATS_EN
  logic              stats_clr;
  logic [NS*16-1:0]  src_pkt_cnt;
  int                m_cnt [NS];
  int                clr_pct;
  bit                clr_force;
`endif

  pkt_tx_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .MOD_W(MW)) dut (
    .clk_156m25     (clk),
    .reset_156m25_n (rst_n),
    .bus            (bus),
    .proto_err      (proto_err)
`ifdef PKT_TX_ARB_STATS_EN
    ,
    .stats_clr      (stats_clr),
    .src_pkt_cnt    (src_pkt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus queues, one per source
  word_t q [NS][$];
  int    seq;

  // reference model: current owner (-1 = nobody), next-priority source, flags
  int          m_owner;
  int          m_ptr;
  bit          m_first;
  bit          m_perr;
  logic [DW-1:0] m_data;
  logic          m_sop, m_eop, m_val;
  logic [MW-1:0] m_mod;

  int n_chk, n_bad;
  int full_pct, gap_pct;
  bit bad0, force_full;
  int cyc;
  int dut_val_cnt;
  int sop_src_log[$];
  int sop_cyc_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic gen_pkt(input int s, input int len, input logic [MW-1:0] mod);
    word_t w;
    for (int i = 0; i < len; i++) begin
      w.data = {8'(s), 24'(seq), 32'($urandom)};
      w.sop  = (i == 0);
      w.eop  = (i == len - 1);
      w.mod  = (i == len - 1) ? mod : MW'($urandom_range(7));
      q[s].push_back(w);
      seq++;
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_first = 0; m_perr = 0;
    m_data = '0; m_sop = 0; m_eop = 0; m_mod = '0; m_val = 0;
`ifdef PKT_TX_ARB_STATS_EN
    foreach (m_cnt[s]) m_cnt[s] = 0;
`endif
  endtask

  // One clock: drive at negedge, check ready, predict, check registered outputs.
  task automatic step();
    logic [NS-1:0] val, exp_rdy;
    word_t w [NS];
    bit full, found;
    int c, o;
    @(negedge clk);
    for (int s = 0; s < NS; s++) begin
      w[s] = '0;
      val[s] = 1'b0;
      if (q[s].size() > 0 && $urandom_range(99) >= gap_pct) begin
        w[s] = q[s][0];
        val[s] = 1'b1;
      end
    end
    if (bad0) begin
      w[0] = '{data: 64'hBAD0, sop: 1'b0, eop: 1'b0, mod: '0};
      val[0] = 1'b1;
    end
    full = force_full || ($urandom_range(99) < full_pct);
    for (int s = 0; s < NS; s++) begin
      bus.src_data[s*DW +: DW] = w[s].data;
      bus.src_mod[s*MW +: MW]  = w[s].mod;
      bus.src_sop[s]           = w[s].sop;
      bus.src_eop[s]           = w[s].eop;
    end
    bus.src_val     = val;
    bus.pkt_tx_full = full;
`ifdef PKT_TX_ARB_STATS_EN
    stats_clr = clr_force || ($urandom_range(99) < clr_pct);
`endif
    exp_rdy = '0;
    if (m_owner >= 0 && !full) exp_rdy[m_owner] = 1'b1;
    #1;
    chk("src_rdy", 64'(bus.src_rdy), 64'(exp_rdy));

    m_val = 1'b0;
    if (m_owner < 0) begin
      for (int s = 0; s < NS; s++) if (val[s] && !w[s].sop) m_perr = 1;
      found = 0;
      for (int k = 0; k < NS; k++) begin
        c = (m_ptr + k) % NS;
        if (!found && val[c] && w[c].sop) begin
          found = 1; m_owner = c; m_first = 1;
        end
      end
    end else if (val[m_owner] && !full) begin
      o = m_owner;
      m_data = w[o].data; m_sop = w[o].sop; m_eop = w[o].eop; m_mod = w[o].mod;
      m_val = 1'b1;
      if (w[o].sop && !m_first) m_perr = 1;
      m_first = 0;
      void'(q[o].pop_front());
      if (w[o].eop) begin
`ifdef PKT_TX_ARB_STATS_EN
        if (m_cnt[o] < 65535) m_cnt[o]++;
`endif
        m_owner = -1;
        m_ptr = (o + 1) % NS;
      end
    end
`ifdef PKT_TX_ARB_STATS_EN
    if (stats_clr) foreach (m_cnt[s]) m_cnt[s] = 0;
`endif

    @(posedge clk);
    #1;
    cyc++;
    chk("tx_val",  64'(bus.pkt_tx_val), 64'(m_val));
    chk("tx_data", bus.pkt_tx_data, m_data);
    chk("tx_sop",  64'(bus.pkt_tx_sop), 64'(m_sop));
    chk("tx_eop",  64'(bus.pkt_tx_eop), 64'(m_eop));
    chk("tx_mod",  64'(bus.pkt_tx_mod), 64'(m_mod));
    chk("proto_err", 64'(proto_err), 64'(m_perr));
`ifdef PKT_TX_ARB_STATS_EN
    for (int s = 0; s < NS; s++)
      chk("pkt_cnt", 64'(src_pkt_cnt[s*16 +: 16]), 64'(m_cnt[s]));
`endif
    if (bus.pkt_tx_val) begin
      dut_val_cnt++;
      if (bus.pkt_tx_sop) begin
        sop_src_log.push_back(int'(bus.pkt_tx_data[63:56]));
        sop_cyc_log.push_back(cyc);
      end
    end
  endtask

  function automatic bit busy();
    bit b = (m_owner >= 0);
    for (int s = 0; s < NS; s++) if (q[s].size() > 0) b = 1;
    return b;
  endfunction

  task automatic drain(input int maxc);
    int n = 0;
    while (busy() && n < maxc) begin
      step();
      n++;
    end
    if (busy()) chk("drain_timeout", 64'd1, 64'd0);
    step();
    step();
  endtask

  // Reset asserted over one edge, possibly mid-packet; everything must read zero.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_val",  64'(bus.pkt_tx_val), 64'd0);
    chk("rst_data", bus.pkt_tx_data, 64'd0);
    chk("rst_sop",  64'(bus.pkt_tx_sop), 64'd0);
    chk("rst_eop",  64'(bus.pkt_tx_eop), 64'd0);
    chk("rst_mod",  64'(bus.pkt_tx_mod), 64'd0);
    chk("rst_rdy",  64'(bus.src_rdy), 64'd0);
    chk("rst_perr", 64'(proto_err), 64'd0);
    for (int s = 0; s < NS; s++) q[s].delete();
    model_reset();
    bus.src_val = '0;
    rst_n = 1'b1;
  endtask

  task automatic clear_logs();
    sop_src_log.delete();
    sop_cyc_log.delete();
    dut_val_cnt = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_bad = 0; seq = 0; cyc = 0;
    full_pct = 0; gap_pct = 0; bad0 = 0; force_full = 0;
    rst_n = 1'b0;
    bus.src_data = '0; bus.src_sop = '0; bus.src_eop = '0;
    bus.src_mod = '0; bus.src_val = '0; bus.pkt_tx_full = 1'b0;
`ifdef PKT_TX_ARB_STATS_EN
    stats_clr = 1'b0; clr_pct = 0; clr_force = 0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // single 4-word packet from source 0, mod 5
    clear_logs();
    gen_pkt(0, 4, 3'd5);
    drain(50);
    chk("p1_nval", 64'(dut_val_cnt), 64'd4);

    // source 0 just finished, so source 1 now wins a simultaneous request
    clear_logs();
    gen_pkt(0, 1, 3'd1);
    gen_pkt(1, 1, 3'd2);
    drain(50);
    chk("p1_prio_a", 64'(sop_src_log[0]), 64'd1);
    chk("p1_prio_b", 64'(sop_src_log[1]), 64'd0);

    // two sources back-to-back 2-word packets: strict alternation, 1 idle cycle
    do_reset();
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      gen_pkt(0, 2, MW'(i));
      gen_pkt(1, 2, MW'(i + 4));
    end
    drain(100);
    chk("p2_npkt", 64'(sop_src_log.size()), 64'd6);
    for (int i = 0; i < sop_src_log.size(); i++) begin
      chk("p2_order", 64'(sop_src_log[i]), 64'(i % 2));
      if (i > 0) chk("p2_gap", 64'(sop_cyc_log[i] - sop_cyc_log[i-1]), 64'd3);
    end

    // MAC full for 3 cycles mid-packet
    clear_logs();
    gen_pkt(2, 8, 3'd3);
    repeat (3) step();
    force_full = 1;
    repeat (3) step();
    force_full = 0;
    drain(50);
    chk("p3_nval", 64'(dut_val_cnt), 64'd8);

    // single-word packets: source 1, then source 0 arriving a cycle later
    clear_logs();
    gen_pkt(1, 1, 3'd7);
    step();
    gen_pkt(0, 1, 3'd6);
    drain(50);
    chk("p4_npkt", 64'(sop_src_log.size()), 64'd2);
    if (sop_cyc_log.size() == 2)
      chk("p4_gap", 64'(sop_cyc_log[1] - sop_cyc_log[0]), 64'd2);

    // source 0 presents a headless word in IDLE; source 1 still flows
    clear_logs();
    bad0 = 1;
    gen_pkt(1, 2, 3'd2);
    drain(50);
    chk("p5_perr", 64'(proto_err), 64'd1);
    chk("p5_src1", 64'(dut_val_cnt), 64'd2);
    bad0 = 0;

    // reset mid-packet
    do_reset();
    gen_pkt(2, 6, 3'd1);
    repeat (3) step();
    do_reset();

`ifdef PKT_TX_ARB_STATS_EN
    for (int i = 0; i < 3; i++) gen_pkt(0, 2, 3'd0);
    drain(100);
    chk("p7_cnt3", 64'(src_pkt_cnt[15:0]), 64'd3);
    clr_force = 1;
    step();
    clr_force = 0;
    chk("p7_clr", 64'(src_pkt_cnt[15:0]), 64'd0);
`endif

    // random traffic with back-pressure and source gaps
    full_pct = 20; gap_pct = 20;
`ifdef PKT_TX_ARB_STATS_EN
    clr_pct = 3;
`endif
    for (int i = 0; i < 600; i++) begin
      for (int s = 0; s < NS; s++)
        if (q[s].size() == 0 && $urandom_range(3) == 0)
          gen_pkt(s, $urandom_range(1, 5), MW'($urandom_range(7)));
      step();
    end
    drain(500);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/pkt_tx_arbiter.md
Name: pkt_tx_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the MAC transmit packet interface between NUM_SRC independent packet sources (e.g. traffic generator, pause/control frame builder, loopback path).
- Sits directly in front of the MAC pkt_tx port, in the 156.25 MHz domain.
- Once a source is granted, it owns the port from SOP through EOP; pkt_tx_full back-pressures the granted source only.
- All pkt_tx outputs are registered.

Parameters:
- NUM_SRC, 2, number of requesting sources (2..8).
- DATA_W, 64, data word width; matches MAC pkt_tx_data.
- MOD_W, 3, byte-valid modulo width; matches MAC pkt_tx_mod.

Ports:
- clk_156m25  in  1  transmit clock, all logic on rising edge.
- reset_156m25_n  in  1  reset; synchronous, active-low.
- src_data  in  NUM_SRC*DATA_W  per-source data, source i at [i*DATA_W +: DATA_W].
- src_sop  in  NUM_SRC  per-source start of packet.
- src_eop  in  NUM_SRC  per-source end of packet.
- src_mod  in  NUM_SRC*MOD_W  per-source byte modulo, valid with eop.
- src_val  in  NUM_SRC  per-source word valid.
- src_rdy  out  NUM_SRC  per-source word accepted this cycle when val&rdy.
- pkt_tx_full  in  1  MAC tx FIFO full.
- pkt_tx_data  out  DATA_W  to MAC.
- pkt_tx_sop  out  1  to MAC.
- pkt_tx_eop  out  1  to MAC.
- pkt_tx_mod  out  MOD_W  to MAC.
- pkt_tx_val  out  1  to MAC.
- proto_err  out  1  sticky protocol error flag.

Behaviour:
- Reset (reset_156m25_n low at a clock edge): all pkt_tx_* = 0, src_rdy = 0, proto_err = 0, state = IDLE, rr_ptr = 0, grant = 0.
- Reset asserted mid-packet truncates the packet at the MAC; this is accepted, and no EOP is synthesised.
- FSM states:
  - IDLE: no owner; src_rdy = 0.
    - Scan sources starting at rr_ptr, wrapping modulo NUM_SRC.
    - Grant the first source i with src_val[i] & src_sop[i].
    - Register grant = i and go to PASS next cycle.
    - A source presenting val without sop in IDLE is never granted. It sets proto_err and its word remains stalled (src_rdy stays 0).
  - PASS: src_rdy[grant] = !pkt_tx_full; all other src_rdy = 0. This is combinational from registered state and pkt_tx_full.
    - Accepted word (val & rdy) is registered onto pkt_tx_* next cycle with pkt_tx_val = 1. Otherwise pkt_tx_val = 0 and data/sop/eop/mod hold.
    - Accepted word with eop: next state IDLE, rr_ptr = (grant+1) mod NUM_SRC.
    - Single-word packet (sop & eop together) is valid: PASS for one accepted word, then IDLE.
    - Accepted word with sop (other than the first word of the packet): forwarded unchanged, proto_err set.
- Latency: source word to pkt_tx_* is 1 cycle.
- Minimum inter-packet gap on pkt_tx_val is 1 idle cycle (the IDLE arbitration cycle).
- pkt_tx_full: sampled combinationally into src_rdy. Because outputs are registered, at most 1 word issues in the cycle after full asserts; MAC FIFO full threshold provides that headroom.
- pkt_tx_mod: passed through registered on every word; meaningful only with eop.
- Fairness: after a packet from source i completes, source i has lowest priority.
- A source that holds val continuously is granted at most once per round.

Optional Feature:
- Macro: PKT_TX_ARB_STATS_EN.
- Defined:
  - Adds output port src_pkt_cnt, NUM_SRC*16 bits: per-source packet counter, incremented on each accepted eop, saturating at 16'hFFFF, cleared by reset.
  - Adds input stats_clr (1 bit), which synchronously zeroes all counters. If clr and an eop acceptance occur in the same cycle, the counter for that source ends at 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package pkt_tx_arb_pkg: typedef arb_state_t {IDLE, PASS}; constants DATA_W_C=64, MOD_W_C=3, CNT_W_C=16; function rr_next(ptr, NUM_SRC).
- One sub-module, pkt_tx_rr_pick: combinational round-robin priority picker (req vector, rr_ptr → one-hot/index grant, any_req).

Test Plan:
- Single source 0 sends a 4-word packet (sop on word 0, eop on word 3, mod=5), MAC never full → pkt_tx_val high 4 consecutive cycles, 1 cycle after each src word; sop/eop on first/last; pkt_tx_mod=5 on the eop word; rr_ptr=1 afterwards.
- Sources 0 and 1 both request continuously with 2-word packets → grants alternate 0,1,0,1; exactly 1 idle cycle between packets on pkt_tx_val.
- pkt_tx_full held high for 3 cycles mid-packet → src_rdy[grant]=0 for those 3 cycles; ≤1 extra pkt_tx_val after the rise; no word lost or duplicated (data sequence compared in order).
- Single-word packet (sop&eop) from source 1, then source 0 → both forwarded; second packet starts 2 cycles after the first word.
- Source 0 drives val without sop in IDLE → proto_err=1, src_rdy[0]=0, source 1 still granted normally.
- Reset pulled low mid-packet → next cycle all pkt_tx_* = 0, src_rdy=0, proto_err=0; with PKT_TX_ARB_STATS_EN defined, 3 completed packets give src_pkt_cnt[0]=3, and stats_clr returns it to 0.
